// File: rtl/enc83_req_queue.sv
// Sequential 8-to-3 request encoder: captures one-hot request pulses into a pending
// register and issues each pending index as a 3-bit code over a valid/ready handshake.
module enc83_req_queue #(
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] d,
    input  logic       clr,
    output logic [2:0] y,
    output logic       valid,
    input  logic       ready,
    output logic [7:0] pending,
    output logic       overrun
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t     state_reg, state_next;
    logic [7:0] pending_reg, pending_next;
    logic [2:0] y_reg, y_next;
    logic       valid_reg, valid_next;
    logic       overrun_reg, overrun_next;

    logic [7:0] y_mask;
    logic [7:0] cons;
    logic [7:0] rem;

    // y_mask is onehot(y); cons is the bit being consumed by this cycle's handshake
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bits
            assign y_mask[gi] = (y_reg == 3'(gi));
            assign cons[gi]   = valid_reg && ready && y_mask[gi];
        end
    endgenerate

    assign rem = pending_reg & ~y_mask;

    function automatic logic [2:0] enc(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        if (LSB_FIRST) begin
            for (int i = 7; i >= 0; i--)
                if (v[i]) idx = 3'(i);
        end else begin
            for (int i = 0; i < 8; i++)
                if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        y_next       = y_reg;
        valid_next   = valid_reg;
        overrun_next = overrun_reg;
        if (clr) begin
            state_next   = IDLE;
            pending_next = 8'h00;
            y_next       = 3'd0;
            valid_next   = 1'b0;
            overrun_next = 1'b0;
        end else begin
            // a request colliding with a bit that is not being consumed is lost
            pending_next = (pending_reg & ~cons) | d;
            overrun_next = overrun_reg | (|(d & pending_reg & ~cons));
            case (state_reg)
                IDLE: begin
                    if (|pending_reg) begin
                        y_next     = enc(pending_reg);
                        valid_next = 1'b1;
                        state_next = HOLD;
                    end
                end
                HOLD: begin
                    // the offered code never changes until it is accepted
                    if (ready) begin
                        if (|rem) begin
                            y_next = enc(rem);
                        end else begin
                            valid_next = 1'b0;
                            state_next = IDLE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            pending_reg <= 8'h00;
            y_reg       <= 3'd0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            y_reg       <= y_next;
            valid_reg   <= valid_next;
            overrun_reg <= overrun_next;
        end
    end

    assign y       = y_reg;
    assign valid   = valid_reg;
    assign pending = pending_reg;
    assign overrun = overrun_reg;

endmodule

// File: tb/tb_enc83_req_queue.sv
// Bench for enc83_req_queue: both priority orders driven in parallel, checked every
// cycle against a queue-level reference model plus directed expectations.
module tb_enc83_req_queue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] d;
    logic       clr;
    logic       ready;

    logic [2:0] y0, y1;
    logic       valid0, valid1;
    logic [7:0] pending0, pending1;
    logic       overrun0, overrun1;

    int compared   = 0;
    int mismatched = 0;

    // reference state, index 0 = MSB-first instance, 1 = LSB-first instance
    bit [7:0] m_pend [2];
    int       m_y    [2];
    bit       m_valid[2];
    bit       m_ovr  [2];

    always #5 clk = ~clk;

    enc83_req_queue #(.LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst_n(rst_n), .d(d), .clr(clr), .y(y0), .valid(valid0),
        .ready(ready), .pending(pending0), .overrun(overrun0)
    );

    enc83_req_queue #(.LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .d(d), .clr(clr), .y(y1), .valid(valid1),
        .ready(ready), .pending(pending1), .overrun(overrun1)
    );

    function automatic int pick(input bit [7:0] v, input int lsb);
        if (lsb != 0) begin
            for (int i = 0; i < 8; i++) if (v[i]) return i;
        end else begin
            for (int i = 7; i >= 0; i--) if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = 8'h00; m_y[k] = 0; m_valid[k] = 1'b0; m_ovr[k] = 1'b0;
        end
    endtask

    // one rising edge of the reference: requests collect into a set, the offered
    // index leaves the set only when accepted, the next offer comes from what is left
    task automatic model_edge();
        bit [7:0] nxt, left;
        int       taken;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            if (clr) begin
                m_pend[k] = 8'h00; m_y[k] = 0; m_valid[k] = 1'b0; m_ovr[k] = 1'b0;
                continue;
            end
            taken = (m_valid[k] && ready) ? m_y[k] : -1;
            nxt = 8'h00;
            for (int i = 0; i < 8; i++) begin
                if (d[i] && m_pend[k][i] && i != taken) m_ovr[k] = 1'b1;
                nxt[i] = (m_pend[k][i] && i != taken) || d[i];
            end
            if (!m_valid[k]) begin
                if (m_pend[k] != 0) begin
                    m_y[k] = pick(m_pend[k], k);
                    m_valid[k] = 1'b1;
                end
            end else if (ready) begin
                left = m_pend[k];
                left[m_y[k]] = 1'b0;
                if (left != 0) m_y[k] = pick(left, k);
                else m_valid[k] = 1'b0;
            end
            m_pend[k] = nxt;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string step);
        check({step, " msb.pending"}, pending0, m_pend[0]);
        check({step, " msb.valid"},   {7'd0, valid0}, {7'd0, m_valid[0]});
        check({step, " msb.y"},       {5'd0, y0}, 8'(m_y[0]));
        check({step, " msb.overrun"}, {7'd0, overrun0}, {7'd0, m_ovr[0]});
        check({step, " lsb.pending"}, pending1, m_pend[1]);
        check({step, " lsb.valid"},   {7'd0, valid1}, {7'd0, m_valid[1]});
        check({step, " lsb.y"},       {5'd0, y1}, 8'(m_y[1]));
        check({step, " lsb.overrun"}, {7'd0, overrun1}, {7'd0, m_ovr[1]});
        $display("step %-12s d=%h rdy=%0d clr=%0d | msb v=%0d y=%0d p=%h o=%0d | lsb v=%0d y=%0d p=%h o=%0d",
                 step, d, ready, clr, valid0, y0, pending0, overrun0, valid1, y1, pending1, overrun1);
    endtask

    task automatic cycle(input string step);
        @(posedge clk);
        model_edge();
        #1;
        check_all(step);
    endtask

    initial begin
        rst_n = 1'b0; d = 8'hFF; ready = 1'b1; clr = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        check("reset.pending_const", pending0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        cycle("rel.e1");
        check("rel.e1.pending", pending0, 8'hFF);
        d = 8'h00;
        cycle("rel.e2");
        check("rel.e2.msb_y", {5'd0, y0}, 8'd7);
        check("rel.e2.lsb_y", {5'd0, y1}, 8'd0);
        ready = 1'b0;
        cycle("rel.hold");
        // asynchronous reset while a code is being offered
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("midrst");
        check("midrst.valid", {7'd0, valid0}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;
        cycle("idle");

        // back-to-back
        d = 8'h24;
        cycle("b2b.e1");
        check("b2b.e1.pending", pending0, 8'h24);
        d = 8'h00;
        cycle("b2b.e2");
        check("b2b.e2.msb_y", {5'd0, y0}, 8'd5);
        check("b2b.e2.lsb_y", {5'd0, y1}, 8'd2);
        cycle("b2b.e3");
        check("b2b.e3.msb_y", {5'd0, y0}, 8'd2);
        check("b2b.e3.lsb_y", {5'd0, y1}, 8'd5);
        check("b2b.e3.pending", pending0, 8'h04);
        cycle("b2b.e4");
        check("b2b.e4.valid", {7'd0, valid0}, 8'd0);
        check("b2b.e4.pending", pending0, 8'h00);

        // hold, no preemption
        ready = 1'b0; d = 8'h04;
        cycle("hold.req");
        d = 8'h00;
        cycle("hold.offer");
        d = 8'h80;
        cycle("hold.hi");
        d = 8'h00;
        for (int i = 0; i < 5; i++) begin
            cycle("hold.wait");
            check("hold.wait.msb_y", {5'd0, y0}, 8'd2);
        end
        check("hold.pending", pending0, 8'h84);
        ready = 1'b1;
        cycle("hold.acc");
        check("hold.acc.msb_y", {5'd0, y0}, 8'd7);
        cycle("hold.drain");
        check("hold.drain.valid", {7'd0, valid0}, 8'd0);

        // overrun and clear
        ready = 1'b0; d = 8'h01;
        cycle("ovr.p1");
        d = 8'h00;
        cycle("ovr.gap");
        d = 8'h01;
        cycle("ovr.p2");
        d = 8'h00;
        check("ovr.flag", {7'd0, overrun0}, 8'd1);
        check("ovr.pending", pending0, 8'h01);
        clr = 1'b1; d = 8'h10;
        cycle("ovr.clr");
        check("ovr.clr.overrun", {7'd0, overrun1}, 8'd0);
        check("ovr.clr.pending", pending1, 8'h00);
        clr = 1'b0; d = 8'h00;
        cycle("ovr.after");

        // re-request of the bit being consumed
        d = 8'h08;
        cycle("rr.req");
        d = 8'h00;
        cycle("rr.offer");
        ready = 1'b1; d = 8'h08;
        cycle("rr.hs");
        check("rr.hs.overrun", {7'd0, overrun0}, 8'd0);
        check("rr.hs.pending", pending0, 8'h08);
        d = 8'h00;
        cycle("rr.reissue");
        check("rr.reissue.y", {5'd0, y0}, 8'd3);
        check("rr.reissue.valid", {7'd0, valid0}, 8'd1);
        cycle("rr.done");

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            d     = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            ready = ($urandom_range(0, 3) != 0);
            clr   = ($urandom_range(0, 40) == 0);
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
